// File: rtl/onehot_decoder_seq.sv
// Sequential binary-to-one-hot decoder: holds y[code] high for HOLD cycles, then forces GAP all-low cycles.
// Optional per-line saturating hit counters when DEC_HIT_CNT_EN is defined.
module onehot_decoder_seq #(
  parameter int SEL_W = 2,
  parameter int HOLD  = 4,
  parameter int GAP   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic [SEL_W-1:0]        in_code,
  output logic                    in_ready,
  output logic [(1<<SEL_W)-1:0]   y,
  output logic                    busy,
  output logic                    done
`ifdef DEC_HIT_CNT_EN
  ,
  input  logic [SEL_W-1:0]        hit_sel,
  output logic [7:0]              hit_cnt
`endif
);

  localparam int N = 1 << SEL_W;
  localparam logic [N-1:0] ONE       = {{(N-1){1'b0}}, 1'b1};
  localparam logic [7:0]   HOLD_INIT = 8'(HOLD - 1);
  localparam logic [7:0]   GAP_INIT  = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_GAP} state_t;

  state_t     state;
  logic [7:0] hold_cnt;
  logic [7:0] gap_cnt;
  logic       accept;

  assign in_ready = (state == ST_IDLE) && en && !rst;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      y        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hold_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            y        <= ONE << in_code;
            hold_cnt <= HOLD_INIT;
            busy     <= 1'b1;
            state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (hold_cnt == 8'd0) begin
            y    <= '0;
            done <= 1'b1;
            // With no gap, returning to IDLE still costs one all-low cycle before the next accept.
            if (GAP > 0) begin
              gap_cnt <= GAP_INIT;
              state   <= ST_GAP;
            end else begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        ST_GAP: begin
          if (gap_cnt == 8'd0) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DEC_HIT_CNT_EN
  logic [7:0] hit_mem [N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) hit_mem[i] <= '0;
    end else if (accept && hit_mem[in_code] != 8'hFF) begin
      hit_mem[in_code] <= hit_mem[in_code] + 8'd1;
    end
  end

  assign hit_cnt = hit_mem[hit_sel];
`endif

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Directed bench for onehot_decoder_seq at default parameters (SEL_W=2, HOLD=4, GAP=1).
module tb_onehot_decoder_seq;
  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       in_valid;
  logic [1:0] in_code;
  logic       in_ready;
  logic [3:0] y;
  logic       busy;
  logic       done;
`ifdef DEC_HIT_CNT_EN
  logic [1:0] hit_sel;
  logic [7:0] hit_cnt;
`endif

  int tests = 0;
  int fails = 0;

  onehot_decoder_seq dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_code(in_code),
    .in_ready(in_ready), .y(y), .busy(busy), .done(done)
`ifdef DEC_HIT_CNT_EN
    , .hit_sel(hit_sel), .hit_cnt(hit_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    tests++;
    if (!in_ready) begin
      $display("FAIL %s ready_timeout got in_ready=%b want 1 within 20 cycles", name, in_ready);
      fails++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_code = 2'd0;
    #1;
    tests++;
    if (in_ready !== 1'b0 || y !== 4'b0000) begin
      $display("FAIL reset_hold got in_ready=%b y=%b want 0 0000", in_ready, y);
      fails++;
    end
    repeat (3) step();
    rst = 1'b0;
    step();
    tests++;
    if (y !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL reset_idle got y=%b busy=%b done=%b rdy=%b want 0000 0 0 1", y, busy, done, in_ready);
      fails++;
    end
  endtask

  task automatic test_single();
    in_code = 2'd2; in_valid = 1'b1;
    wait_ready("single");
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (y !== 4'b0100 || done !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
        $display("FAIL single_hold c%0d got y=%b done=%b busy=%b rdy=%b want 0100 0 1 0", i, y, done, busy, in_ready);
        fails++;
      end
      step();
    end
    tests++;
    if (y !== 4'b0000 || done !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL single_end got y=%b done=%b busy=%b want 0000 1 1", y, done, busy);
      fails++;
    end
    step();
    tests++;
    if (y !== 4'b0000 || done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL single_idle got y=%b done=%b busy=%b rdy=%b want 0000 0 0 1", y, done, busy, in_ready);
      fails++;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_code = 2'(k);
      exp = 4'b0001 << k;
      tests++;
      if (in_ready !== 1'b1) begin
        $display("FAIL b2b_ready k%0d got %b want 1", k, in_ready);
        fails++;
      end
      step();
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (y !== exp || $countones(y) > 1) begin
          $display("FAIL b2b_hold k%0d c%0d got y=%b want %b", k, i, y, exp);
          fails++;
        end
        step();
      end
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (y !== 4'b0000) begin
          $display("FAIL b2b_gap k%0d c%0d got y=%b want 0000", k, i, y);
          fails++;
        end
        if (i == 0) step();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_en_gating();
    en = 1'b0; in_valid = 1'b1; in_code = 2'd3;
    repeat (3) begin
      step();
      tests++;
      if (in_ready !== 1'b0 || y !== 4'b0000 || busy !== 1'b0) begin
        $display("FAIL en_block got rdy=%b y=%b busy=%b want 0 0000 0", in_ready, y, busy);
        fails++;
      end
    end
    en = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      $display("FAIL en_raise got rdy=%b want 1", in_ready);
      fails++;
    end
    step();
    en = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (y !== 4'b1000) begin
        $display("FAIL en_drop_hold c%0d got y=%b want 1000", i, y);
        fails++;
      end
      step();
    end
    tests++;
    if (y !== 4'b0000 || done !== 1'b1) begin
      $display("FAIL en_drop_end got y=%b done=%b want 0000 1", y, done);
      fails++;
    end
    step();
    tests++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      $display("FAIL en_idle_blocked got busy=%b rdy=%b want 0 0", busy, in_ready);
      fails++;
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid_hold();
    in_code = 2'd1; in_valid = 1'b1;
    wait_ready("rst_mid");
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    tests++;
    if (y !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
      $display("FAIL rst_mid_async got y=%b busy=%b done=%b rdy=%b want 0000 0 0 0", y, busy, done, in_ready);
      fails++;
    end
    step();
    rst = 1'b0;
    #1;
    tests++;
    if (done !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL rst_mid_release got done=%b rdy=%b want 0 1", done, in_ready);
      fails++;
    end
    in_code = 2'd3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (y !== 4'b1000) begin
        $display("FAIL rst_mid_after c%0d got y=%b want 1000", i, y);
        fails++;
      end
      step();
    end
    tests++;
    if (y !== 4'b0000 || done !== 1'b1) begin
      $display("FAIL rst_mid_done got y=%b done=%b want 0000 1", y, done);
      fails++;
    end
  endtask

`ifdef DEC_HIT_CNT_EN
  task automatic accept_code(input logic [1:0] c);
    in_code = c; in_valid = 1'b1;
    wait_ready("hit_accept");
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_hit_cnt();
    logic [7:0] exp [4];
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    exp[0] = 8'd255; exp[1] = 8'd3; exp[2] = 8'd0; exp[3] = 8'd0;
    repeat (3) accept_code(2'd1);
    repeat (300) accept_code(2'd0);
    for (int s = 0; s < 4; s++) begin
      hit_sel = 2'(s);
      #1;
      tests++;
      if (hit_cnt !== exp[s]) begin
        $display("FAIL hit_cnt sel%0d got %0d want %0d", s, hit_cnt, exp[s]);
        fails++;
      end
    end
  endtask
`endif

  initial begin
`ifdef DEC_HIT_CNT_EN
    hit_sel = 2'd0;
`endif
    test_reset();
    test_single();
    test_back_to_back();
    test_en_gating();
    test_reset_mid_hold();
`ifdef DEC_HIT_CNT_EN
    test_hit_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
